// File: rtl/snn_pkg.sv
// Shared address map, control-bit positions and saturating arithmetic for the
// parametrised spiking network.
package snn_pkg;

    localparam int unsigned ADDR_THRESHOLD = 0;
    localparam int unsigned ADDR_LEAK      = 1;
    localparam int unsigned ADDR_REFRAC    = 2;
    localparam int unsigned ADDR_CTRL      = 3;
    localparam int unsigned ADDR_W1_BASE   = 4;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;

    // Unsigned add clamped at 2^w-1; callers cast the result back to w bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << w) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/snn_network_param_lif.sv
// Leaky integrate-and-fire neuron: membrane potential, refractory counter and
// registered spike output.
module lif_neuron_p
    import snn_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] current,
    input  logic [W-1:0] threshold,
    input  logic [W-1:0] leak,
    input  logic [W-1:0] refrac,
    output logic         spike
);

    logic [W-1:0] v;
    logic [W-1:0] rc;
    logic [W-1:0] t_int;
    logic [W-1:0] t_leak;

    always_comb begin
        t_int  = W'(sat_add(32'(v), 32'(current), W));
        t_leak = (t_int > leak) ? t_int - leak : '0;
    end

    // Clear outranks enable so a combined clear+disable leaves the state zeroed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v     <= '0;
            rc    <= '0;
            spike <= 1'b0;
        end else if (clr) begin
            v     <= '0;
            rc    <= '0;
            spike <= 1'b0;
        end else if (!en) begin
            spike <= 1'b0;
        end else if (rc != '0) begin
            rc    <= rc - 1'b1;
            v     <= '0;
            spike <= 1'b0;
        end else if (t_leak >= threshold) begin
            v     <= '0;
            rc    <= refrac;
            spike <= 1'b1;
        end else begin
            v     <= t_leak;
            spike <= 1'b0;
        end
    end

endmodule

// File: rtl/snn_network_param.sv
// Two-layer LIF network with configuration bank, registered readback,
// saturating current summers and registered output-layer currents.
module snn_network_param
    import snn_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_HID  = 4,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned W      = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [W-1:0]      cfg_wdata,
    output logic [W-1:0]      cfg_rdata,
    input  logic [N_IN-1:0]   spikes_in,
    output logic [N_OUT-1:0]  spikes_out
);

    localparam int unsigned N_W1    = N_HID * N_IN;
    localparam int unsigned N_W2    = N_OUT * N_HID;
    localparam int unsigned W2_BASE = ADDR_W1_BASE + N_W1;

    logic [W-1:0] threshold;
    logic [W-1:0] leak;
    logic [W-1:0] refrac;
    logic         enable;
    logic         clr_pend;

    logic [W-1:0] w1 [N_W1];
    logic [W-1:0] w2 [N_W2];
    logic [W-1:0] i1 [N_HID];
    logic [W-1:0] i2 [N_OUT];
    logic [W-1:0] i2_next [N_OUT];
    logic [W-1:0] rd_word;

    logic [N_HID-1:0] hid_spike;

    // The clear bit is held for exactly one cycle so it acts on the edge after the write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            threshold <= '1;
            leak      <= '0;
            refrac    <= '0;
            enable    <= 1'b1;
            clr_pend  <= 1'b0;
            for (int unsigned k = 0; k < N_W1; k++) w1[k] <= '0;
            for (int unsigned k = 0; k < N_W2; k++) w2[k] <= '0;
        end else begin
            clr_pend <= 1'b0;
            if (cfg_we) begin
                if (cfg_addr == ADDR_W'(ADDR_THRESHOLD)) threshold <= cfg_wdata;
                if (cfg_addr == ADDR_W'(ADDR_LEAK))      leak      <= cfg_wdata;
                if (cfg_addr == ADDR_W'(ADDR_REFRAC))    refrac    <= cfg_wdata;
                if (cfg_addr == ADDR_W'(ADDR_CTRL)) begin
                    enable   <= cfg_wdata[CTRL_EN_BIT];
                    clr_pend <= cfg_wdata[CTRL_CLR_BIT];
                end
                for (int unsigned k = 0; k < N_W1; k++)
                    if (cfg_addr == ADDR_W'(ADDR_W1_BASE + k)) w1[k] <= cfg_wdata;
                for (int unsigned k = 0; k < N_W2; k++)
                    if (cfg_addr == ADDR_W'(W2_BASE + k)) w2[k] <= cfg_wdata;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (cfg_addr == ADDR_W'(ADDR_THRESHOLD)) rd_word = threshold;
        if (cfg_addr == ADDR_W'(ADDR_LEAK))      rd_word = leak;
        if (cfg_addr == ADDR_W'(ADDR_REFRAC))    rd_word = refrac;
        if (cfg_addr == ADDR_W'(ADDR_CTRL))      rd_word[CTRL_EN_BIT] = enable;
        for (int unsigned k = 0; k < N_W1; k++)
            if (cfg_addr == ADDR_W'(ADDR_W1_BASE + k)) rd_word = w1[k];
        for (int unsigned k = 0; k < N_W2; k++)
            if (cfg_addr == ADDR_W'(W2_BASE + k)) rd_word = w2[k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       cfg_rdata <= '0;
        else if (cfg_re) cfg_rdata <= rd_word;
    end

    always_comb begin
        for (int unsigned h = 0; h < N_HID; h++) begin
            i1[h] = '0;
            for (int unsigned i = 0; i < N_IN; i++)
                if (spikes_in[i]) i1[h] = W'(sat_add(32'(i1[h]), 32'(w1[h*N_IN + i]), W));
        end
        for (int unsigned o = 0; o < N_OUT; o++) begin
            i2_next[o] = '0;
            for (int unsigned h = 0; h < N_HID; h++)
                if (hid_spike[h]) i2_next[o] = W'(sat_add(32'(i2_next[o]), 32'(w2[o*N_HID + h]), W));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clr_pend) begin
            for (int unsigned o = 0; o < N_OUT; o++) i2[o] <= '0;
        end else if (enable) begin
            for (int unsigned o = 0; o < N_OUT; o++) i2[o] <= i2_next[o];
        end
    end

    for (genvar h = 0; h < N_HID; h++) begin : g_hid
        lif_neuron_p #(.W(W)) u_neuron (
            .clk       (clk),
            .reset     (reset),
            .en        (enable),
            .clr       (clr_pend),
            .current   (i1[h]),
            .threshold (threshold),
            .leak      (leak),
            .refrac    (refrac),
            .spike     (hid_spike[h])
        );
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        lif_neuron_p #(.W(W)) u_neuron (
            .clk       (clk),
            .reset     (reset),
            .en        (enable),
            .clr       (clr_pend),
            .current   (i2[o]),
            .threshold (threshold),
            .leak      (leak),
            .refrac    (refrac),
            .spike     (spikes_out[o])
        );
    end

endmodule

// File: tb/tb_snn_network_param.sv
// Directed and randomized checks of snn_network_param against an edge-level
// behavioural model of the network.
module tb_snn_network_param;

    localparam int NI    = 4;
    localparam int NH    = 4;
    localparam int NO    = 4;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int MAXV  = (1 << DW) - 1;
    localparam int B2    = 4 + NH*NI;
    localparam int LASTA = B2 + NO*NH;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic          cfg_re;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic [DW-1:0] cfg_rdata;
    logic [NI-1:0] spikes_in;
    logic [NO-1:0] spikes_out;

    always #5 clk = ~clk;

    snn_network_param #(
        .N_IN   (NI),
        .N_HID  (NH),
        .N_OUT  (NO),
        .W      (DW),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_re     (cfg_re),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .spikes_in  (spikes_in),
        .spikes_out (spikes_out)
    );

    int n_cmp = 0;
    int n_mis = 0;

    int m_thr, m_leak, m_ref, m_rd;
    bit m_en, m_clr;
    int m_w1 [NH][NI];
    int m_w2 [NO][NH];
    int m_vh [NH];
    int m_rh [NH];
    int m_vo [NO];
    int m_ro [NO];
    int m_i2 [NO];
    bit m_sh [NH];
    bit m_so [NO];

    function automatic int sat(input int x);
        return (x > MAXV) ? MAXV : x;
    endfunction

    task automatic lif(input int v, input int rc, input int cur,
                       output int nv, output int nrc, output bit ns);
        int t;
        if (rc != 0) begin
            nv = 0; nrc = rc - 1; ns = 0;
        end else begin
            t = sat(v + cur);
            t = (t > m_leak) ? t - m_leak : 0;
            if (t >= m_thr) begin
                nv = 0; nrc = m_ref; ns = 1;
            end else begin
                nv = t; nrc = 0; ns = 0;
            end
        end
    endtask

    function automatic int word(input int a);
        if (a == 0) return m_thr;
        if (a == 1) return m_leak;
        if (a == 2) return m_ref;
        if (a == 3) return int'(m_en);
        if (a >= 4 && a < B2) return m_w1[(a-4)/NI][(a-4)%NI];
        if (a >= B2 && a < LASTA) return m_w2[(a-B2)/NH][(a-B2)%NH];
        return 0;
    endfunction

    task automatic model_reset();
        m_thr = MAXV; m_leak = 0; m_ref = 0; m_rd = 0; m_en = 1; m_clr = 0;
        m_w1 = '{default:0}; m_w2 = '{default:0};
        m_vh = '{default:0}; m_rh = '{default:0}; m_sh = '{default:0};
        m_vo = '{default:0}; m_ro = '{default:0}; m_so = '{default:0};
        m_i2 = '{default:0};
    endtask

    task automatic model_edge(input bit we, input bit re, input int a, input int wd,
                              input logic [NI-1:0] sp);
        int nvh [NH]; int nrh [NH]; bit nsh [NH];
        int nvo [NO]; int nro [NO]; bit nso [NO];
        int ni2 [NO];
        int cur;
        if (re) m_rd = word(a);
        nvh = m_vh; nrh = m_rh; nvo = m_vo; nro = m_ro; ni2 = m_i2;
        nsh = '{default:0}; nso = '{default:0};
        if (m_clr) begin
            nvh = '{default:0}; nrh = '{default:0};
            nvo = '{default:0}; nro = '{default:0};
            ni2 = '{default:0};
        end else if (m_en) begin
            for (int h = 0; h < NH; h++) begin
                cur = 0;
                for (int i = 0; i < NI; i++) if (sp[i]) cur += m_w1[h][i];
                lif(m_vh[h], m_rh[h], sat(cur), nvh[h], nrh[h], nsh[h]);
            end
            for (int o = 0; o < NO; o++) begin
                cur = 0;
                for (int h = 0; h < NH; h++) if (m_sh[h]) cur += m_w2[o][h];
                ni2[o] = sat(cur);
                lif(m_vo[o], m_ro[o], m_i2[o], nvo[o], nro[o], nso[o]);
            end
        end
        m_vh = nvh; m_rh = nrh; m_sh = nsh;
        m_vo = nvo; m_ro = nro; m_so = nso; m_i2 = ni2;
        m_clr = 0;
        if (we) begin
            if (a == 0) m_thr = wd;
            if (a == 1) m_leak = wd;
            if (a == 2) m_ref = wd;
            if (a == 3) begin
                m_en  = (wd & 1) != 0;
                m_clr = (wd & 2) != 0;
            end
            if (a >= 4 && a < B2) m_w1[(a-4)/NI][(a-4)%NI] = wd;
            if (a >= B2 && a < LASTA) m_w2[(a-B2)/NH][(a-B2)%NH] = wd;
        end
    endtask

    function automatic logic [NO-1:0] m_out();
        logic [NO-1:0] r;
        for (int o = 0; o < NO; o++) r[o] = m_so[o];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit we, input bit re, input int a, input int wd,
                        input logic [NI-1:0] sp);
        cfg_we    = we;
        cfg_re    = re;
        cfg_addr  = AW'(a);
        cfg_wdata = DW'(wd);
        spikes_in = sp;
        @(posedge clk);
        model_edge(we, re, a, wd, sp);
        #1;
        chk("spikes_out", 32'(spikes_out), 32'(m_out()));
        chk("cfg_rdata", 32'(cfg_rdata), 32'(m_rd));
    endtask

    task automatic wr(input int a, input int wd);
        step(1'b1, 1'b0, a, wd, '0);
    endtask

    task automatic rd(input int a);
        step(1'b0, 1'b1, a, 0, '0);
    endtask

    initial begin
        logic [11:0] train12;
        logic [5:0]  train6;
        int          r, a, d;

        reset = 1'b1; cfg_we = 1'b0; cfg_re = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; spikes_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_spikes", 32'(spikes_out), 32'd0);
        chk("reset_rdata", 32'(cfg_rdata), 32'd0);
        reset = 1'b0;

        // Reset-value readback
        rd(0);  chk("t1_thr", 32'(cfg_rdata), 32'hFF);
        rd(3);  chk("t1_ctrl", 32'(cfg_rdata), 32'h01);
        rd(4);  chk("t1_w1", 32'(cfg_rdata), 32'h00);
        rd(63); chk("t1_oob", 32'(cfg_rdata), 32'h00);

        // Single spike through both layers
        wr(0, 10); wr(4, 10); wr(B2, 10);
        step(1'b0, 1'b0, 0, 0, 4'b0001);
        chk("t2_e0", 32'(spikes_out), 32'd0);
        step(1'b0, 1'b0, 0, 0, 4'b0000);
        chk("t2_e1", 32'(spikes_out), 32'd0);
        step(1'b0, 1'b0, 0, 0, 4'b0000);
        chk("t2_e2", 32'(spikes_out), 32'b0001);
        step(1'b0, 1'b0, 0, 0, 4'b0000);
        chk("t2_e3", 32'(spikes_out), 32'd0);

        // Saturating hidden current
        wr(0, 255);
        for (int i = 0; i < NI; i++) wr(4 + NI + i, 200);
        wr(B2 + 1, 255);
        step(1'b0, 1'b0, 0, 0, 4'b1111);
        step(1'b0, 1'b0, 0, 0, 4'b0000);
        step(1'b0, 1'b0, 0, 0, 4'b0000);
        chk("t3_e2", 32'(spikes_out), 32'b0001);

        // Leak and refractory timing
        wr(0, 20); wr(1, 3); wr(2, 2); wr(4, 8); wr(B2, 255); wr(B2 + 1, 0);
        wr(3, 3);
        step(1'b0, 1'b0, 0, 0, 4'b0000);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 0, 0, 4'b0001);
            train12[k] = spikes_out[0];
        end
        chk("t4_train", 32'(train12), 32'b1000_0010_0000);

        // Clear mid-integration, freeze, resume
        wr(3, 3);
        step(1'b0, 1'b0, 0, 0, 4'b0000);
        repeat (3) step(1'b0, 1'b0, 0, 0, 4'b0001);
        wr(3, 3);
        step(1'b0, 1'b0, 0, 0, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 0, 0, 4'b0001);
            train6[k] = spikes_out[0];
        end
        chk("t5_after_clr", 32'(train6), 32'b100000);
        step(1'b1, 1'b0, 3, 0, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 0, 0, 4'b0001);
            chk("t5_frozen", 32'(spikes_out), 32'd0);
        end
        step(1'b1, 1'b0, 3, 1, 4'b0001);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 0, 0, 4'b0001);
            train6[k] = spikes_out[0];
        end
        chk("t5_resume", 32'(train6), 32'b010000);

        // Out-of-range access
        wr(50, 8'h55);
        rd(50); chk("t6_oob", 32'(cfg_rdata), 32'd0);
        rd(0);  chk("t6_thr", 32'(cfg_rdata), 32'd20);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 11);
            a = 0; d = 0;
            if (r < 3) begin
                a = $urandom_range(4, LASTA - 1); d = $urandom_range(0, MAXV);
            end else if (r == 3) begin
                a = 0; d = $urandom_range(0, 60);
            end else if (r == 4) begin
                a = 1; d = $urandom_range(0, 7);
            end else if (r == 5) begin
                a = 2; d = $urandom_range(0, 3);
            end else if (r == 6) begin
                a = 3; d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 1;
            end
            if ($urandom_range(0, 1) == 1 && r > 6) a = $urandom_range(0, 63);
            step(r <= 6, $urandom_range(0, 1) == 1, a, d, NI'($urandom_range(0, MAXV)));
        end

        // Asynchronous reset mid-accumulation
        wr(3, 3); wr(0, 200); wr(1, 0); wr(2, 0); wr(4, 8);
        repeat (5) step(1'b0, 1'b1, 0, 0, 4'b0001);
        reset = 1'b1;
        #1;
        chk("t6_rst_spikes", 32'(spikes_out), 32'd0);
        chk("t6_rst_rdata", 32'(cfg_rdata), 32'd0);
        model_reset();
        #2;
        reset = 1'b0;
        rd(0); chk("t6_rst_thr", 32'(cfg_rdata), 32'hFF);
        rd(3); chk("t6_rst_ctrl", 32'(cfg_rdata), 32'h01);
        rd(4); chk("t6_rst_w1", 32'(cfg_rdata), 32'h00);
        repeat (4) step(1'b0, 1'b0, 0, 0, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
